alu_arbiter: RTL

//  Shares one combinational 32-bit ALU between two requesters.

---
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter: two op request channels and
// one response channel whose valid bits name the owning requester.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [5:0]         req_op;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carryout;
    logic               rsp_zero;
    logic               rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, latch operands,
// capture result and flags one cycle later, hold the response until consumed.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             grant_s;
    logic [1:0]       req_ready_s;
    logic             accept_s;
    logic             rsp_hs_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [2:0]       sel_op_s;

    // Grant selection: sole requester wins; a tie goes to req0 or alternates
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11: begin
                if (FIXED_PRI) begin
                    grant_s = 1'b0;
                end else begin
                    grant_s = ~last_grant_q;
                end
            end
            default: grant_s = 1'b0;
        endcase
    end

    // Accept handshake and operand mux for the granted requester
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_q == ST_IDLE) && bus.req_valid[grant_s]) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
        accept_s = |req_ready_s;
        rsp_hs_s = (state_q == ST_RESP) && bus.rsp_ready[owner_q];
        if (grant_s) begin
            sel_a_s  = bus.req_a[2*WIDTH-1:WIDTH];
            sel_b_s  = bus.req_b[2*WIDTH-1:WIDTH];
            sel_op_s = bus.req_op[5:3];
        end else begin
            sel_a_s  = bus.req_a[WIDTH-1:0];
            sel_b_s  = bus.req_b[WIDTH-1:0];
            sel_op_s = bus.req_op[2:0];
        end
    end

    // Next-state logic; ALU inputs only change on an accept so the ALU never sees glitches
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_valid_d  = rsp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_ISSUE;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    alu_a_d      = sel_a_s;
                    alu_b_d      = sel_b_s;
                    alu_ctl_d    = sel_op_s;
                    busy_d       = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d      = ST_RESP;
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carryout;
                rsp_zero_d   = alu_zero;
                rsp_ovf_d    = alu_overflow;
                rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 2'b00;
                    busy_d      = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 2'b00;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= {WIDTH{1'b0}};
            alu_b_q      <= {WIDTH{1'b0}};
            alu_ctl_q    <= 3'b000;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carryout = rsp_carry_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_control      = alu_ctl_q;
    assign busy             = busy_q;

endmodule
